// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for alu_share_arbiter: ALU op codes, FSM states, data width.
package alu_share_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last+1 (mod NREQ) for the first valid.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!any && valid[i] && (i == ((int'(last) + off) % NREQ))) begin
          grant[i] = 1'b1;
          idx      = IDW'(i);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters.
// Optional per-requester grant counters under ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*OP_W-1:0]     req_op,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_op,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_result,
  output logic                     rsp_zero,
  output logic [IDW-1:0]           rsp_id
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]   stat_grants
`endif
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  alu_req_t          sel_req;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // One-hot grant lets the operand mux be a plain AND-OR.
  always_comb begin
    sel_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_req.a  = req_a[i*DATA_W +: DATA_W];
        sel_req.b  = req_b[i*DATA_W +: DATA_W];
        sel_req.op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          alu_a_d  = sel_req.a;
          alu_b_d  = sel_req.b;
          alu_op_d = sel_req.op;
          rsp_id_d = grant_idx;
          last_d   = grant_idx;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= IDW'(NREQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_id     = rsp_id_q;

`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic              handshake;
  logic [STAT_W-1:0] stat_q [NREQ];
  logic [STAT_W-1:0] stat_d [NREQ];

  assign handshake = (state_q == ST_IDLE) && grant_any;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_d[i] = (handshake && grant[i]) ? sat_inc(stat_q[i]) : stat_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (reset) stat_q[i] <= '0;
      else       stat_q[i] <= stat_d[i];
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_grants[i*STAT_W +: STAT_W] = stat_q[i];
    end
  end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (add/sub/and/or/xor, 4-bit op code, 32-bit result plus zero flag) between NREQ requesters, e.g. the core datapath and a debug/CSR side-port.
- Each requester uses a valid/ready request channel. The block registers the operands, drives the ALU for one cycle, captures result and zero, then returns them on one shared response channel tagged with the requester ID.
- Arbitration is round-robin.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  NREQ*32  operand B; same packing as req_a.
- req_op  in  NREQ*4  ALU op code; requester i occupies bits [4i+3:4i].
- alu_a  out  32  registered operand A to the ALU.
- alu_b  out  32  registered operand B to the ALU.
- alu_op  out  4  registered op code to the ALU.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_id  out  IDW  index of the requester that owns the response.

Behaviour:
- State machine: IDLE -> EXEC -> RESP -> IDLE. Reset state is IDLE.
- Reset values: all outputs 0, last-grant pointer = NREQ-1, so requester 0 wins first.
- IDLE:
  - req_ready is combinational and one-hot. Scan starts at last+1, wraps modulo NREQ, and selects the first i with req_valid[i]=1.
  - Handshake occurs when req_valid[i] & req_ready[i].
  - On handshake: latch that requester's operands and op into alu_a/alu_b/alu_op, latch i into rsp_id, update last=i, go to EXEC.
  - With no valid request: stay in IDLE, req_ready=0.
- EXEC:
  - req_ready=0.
  - alu_* are stable for the whole cycle.
  - At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP.
- RESP:
  - rsp_valid=1. rsp_result, rsp_zero and rsp_id are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid drops next cycle and the state returns to IDLE.
  - req_ready=0 throughout RESP.
- Latency:
  - Request accepted in cycle T; rsp_valid first high in cycle T+2.
  - Minimum issue interval is 3 cycles with rsp_ready tied high.
- alu_a/alu_b/alu_op hold their last values outside EXEC; they are not cleared.
- Op codes are passed through unchecked. Codes 5..15 yield ALU result 0, so rsp_zero=1.
- Requests are not cancellable: once req_valid rises it must stay high until the handshake.
- Simultaneous requests are resolved by round-robin. A requester that was just granted has lowest priority in the next IDLE cycle.
- Reset asserted in any state: next cycle the state is IDLE with reset values. An in-flight operation is dropped and no response is issued.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- With the macro defined:
  - Extra output stat_grants (NREQ*16), one 16-bit counter per requester, packed like req_a.
  - Counter i increments on each request handshake of requester i and saturates at 16'hFFFF.
  - Counters clear on reset.
- Without the macro: the port and the counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - ALU op constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - FSM state encodings: IDLE=0, EXEC=1, RESP=2.
  - Data width constant 32.
- One natural sub-module: rr_pick. It is combinational and takes the valid vector and last pointer, producing a one-hot grant and the encoded index. It is reusable by other shared-resource blocks.
- The FSM, operand registers and response registers stay in the top module.

Test Plan:
- Single add: req0 a=5, b=7, op=0, rsp_ready=1 -> req_ready[0] high in cycle T; rsp_valid in T+2 with result=12, zero=0, id=0.
- Sub to zero: req1 a=b=32'h1234, op=1 -> rsp_result=0, rsp_zero=1, rsp_id=1.
- Fairness: both requesters hold valid continuously for 4 ops, rsp_ready=1 -> grant order 0,1,0,1; never two consecutive grants to the same requester while both are valid.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result/rsp_zero/rsp_id stable and req_ready=0 throughout; accept and return to IDLE one cycle after rsp_ready=1.
- Illegal op: op=4'hF, a=32'hFFFFFFFF -> rsp_result=0, rsp_zero=1.
- Reset mid-operation: assert reset during EXEC with req0 valid -> next cycle rsp_valid=0, all outputs 0, and the first grant after reset goes to requester 0.
